// File: rtl/fetch_pkg.sv
// Shared fetch-stage types and constants.
// Fetch FSM states, NOP encoding, instruction length, reset PC.
package fetch_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    HOLD,
    DRAIN,
    FAULT
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;
  localparam logic [31:0] ILEN_BYTES   = 32'd4;
  localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/instr_fetch.sv
// OTTER instruction fetch: one-outstanding imem reads into IR.
// Optional macro FETCH_MISALIGN_TRAP_EN adds the misaligned-redirect FAULT state.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEF_RESET_PC
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        REDIRECT,
  input  logic [31:0] REDIRECT_PC,
  output logic        IMEM_REQ,
  output logic [31:0] IMEM_ADDR,
  input  logic        IMEM_GNT,
  input  logic        IMEM_RVALID,
  input  logic [31:0] IMEM_RDATA,
  output logic [31:0] IR,
  output logic [31:0] IR_PC,
  output logic        IR_VALID,
  input  logic        IR_READY,
  output logic        FETCH_FAULT
);

  fetch_state_e state;
  logic [31:0]  fetch_pc;
  logic         pend_n;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic pend;
  logic misal;
  logic fault;

  assign misal       = REDIRECT_PC[1:0] != 2'b00;
  assign FETCH_FAULT = fault;
`else
  assign FETCH_FAULT = 1'b0;
`endif

  // Request/address come from registered state only.
  assign IMEM_REQ  = (state == REQ);
  assign IMEM_ADDR = fetch_pc;

  // An accepted request is still owed a response after this cycle.
  always_comb begin
    pend_n = 1'b0;
    unique case (state)
      REQ:         pend_n = IMEM_GNT;
      WAIT, DRAIN: pend_n = !IMEM_RVALID;
`ifdef FETCH_MISALIGN_TRAP_EN
      FAULT:       pend_n = pend && !IMEM_RVALID;
`endif
      default:     pend_n = 1'b0;
    endcase
  end

  // Fetch FSM with redirect taking priority over memory/handshake.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      IR       <= NOP_INSTR;
      IR_PC    <= 32'h0;
      IR_VALID <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
      pend     <= 1'b0;
      fault    <= 1'b0;
`endif
    end else if (REDIRECT) begin
      IR_VALID <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
      pend <= pend_n;
      if (misal) begin
        fault <= 1'b1;
        state <= FAULT;
      end else begin
        fault    <= 1'b0;
        fetch_pc <= REDIRECT_PC;
        state    <= pend_n ? DRAIN : REQ;
      end
`else
      fetch_pc <= REDIRECT_PC & ~32'h3;
      state    <= pend_n ? DRAIN : REQ;
`endif
    end else begin
      unique case (state)
        IDLE: state <= REQ;
        REQ: begin
          if (IMEM_GNT) state <= WAIT;
        end
        WAIT: begin
          if (IMEM_RVALID) begin
            IR       <= IMEM_RDATA;
            IR_PC    <= fetch_pc;
            IR_VALID <= 1'b1;
            fetch_pc <= fetch_pc + ILEN_BYTES;
            state    <= HOLD;
          end
        end
        HOLD: begin
          if (IR_READY) begin
            IR_VALID <= 1'b0;
            state    <= REQ;
          end
        end
        DRAIN: begin
          if (IMEM_RVALID) state <= REQ;
        end
`ifdef FETCH_MISALIGN_TRAP_EN
        FAULT: begin
          if (IMEM_RVALID) pend <= 1'b0;
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed vectors plus a
// transaction-level fetch model compared on every falling edge.
module tb_instr_fetch;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic        REDIRECT = 1'b0;
  logic [31:0] REDIRECT_PC = 32'h0;
  logic        IMEM_REQ;
  logic [31:0] IMEM_ADDR;
  logic        IMEM_GNT = 1'b0;
  logic        IMEM_RVALID = 1'b0;
  logic [31:0] IMEM_RDATA = 32'h0;
  logic [31:0] IR;
  logic [31:0] IR_PC;
  logic        IR_VALID;
  logic        IR_READY = 1'b0;
  logic        FETCH_FAULT;

  int errors = 0;
  int checks = 0;

  instr_fetch dut (
    .CLK(CLK),
    .RST_N(RST_N),
    .REDIRECT(REDIRECT),
    .REDIRECT_PC(REDIRECT_PC),
    .IMEM_REQ(IMEM_REQ),
    .IMEM_ADDR(IMEM_ADDR),
    .IMEM_GNT(IMEM_GNT),
    .IMEM_RVALID(IMEM_RVALID),
    .IMEM_RDATA(IMEM_RDATA),
    .IR(IR),
    .IR_PC(IR_PC),
    .IR_VALID(IR_VALID),
    .IR_READY(IR_READY),
    .FETCH_FAULT(FETCH_FAULT)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Model: a request is presented, a response may be owed (and maybe
  // stale), the IR may be full, a fault may be latched.
  bit          m_start, m_req, m_out, m_stale, m_full, m_fault;
  logic [31:0] m_pc, m_ir, m_irpc;

  always @(posedge CLK or negedge RST_N) begin
    bit resp, acc, still_out;
    if (!RST_N) begin
      m_start = 1; m_req = 0; m_out = 0; m_stale = 0;
      m_full = 0; m_fault = 0;
      m_pc = 32'h0; m_ir = 32'h13; m_irpc = 32'h0;
    end else begin
      resp      = m_out && IMEM_RVALID;
      acc       = m_req && IMEM_GNT;
      still_out = (m_out && !IMEM_RVALID) || acc;
      if (REDIRECT) begin
        m_full  = 0;
        m_start = 0;
        m_out   = still_out;
        m_stale = still_out;
`ifdef FETCH_MISALIGN_TRAP_EN
        if (REDIRECT_PC[1:0] != 2'b00) begin
          m_fault = 1;
          m_req   = 0;
        end else begin
          m_fault = 0;
          m_pc    = REDIRECT_PC;
          m_req   = !still_out;
        end
`else
        m_pc  = {REDIRECT_PC[31:2], 2'b00};
        m_req = !still_out;
`endif
      end else if (m_start) begin
        m_start = 0;
        m_req   = 1;
      end else if (acc) begin
        m_req = 0;
        m_out = 1;
      end else if (resp) begin
        m_out = 0;
        if (m_stale) begin
          m_stale = 0;
          m_req   = !m_fault;
        end else begin
          m_ir   = IMEM_RDATA;
          m_irpc = m_pc;
          m_full = 1;
          m_pc   = m_pc + 32'd4;
        end
      end else if (m_full && IR_READY) begin
        m_full = 0;
        m_req  = 1;
      end
    end
  end

  // Continuous comparison against the model.
  always @(negedge CLK) begin
    chk("req",   {31'b0, IMEM_REQ},    {31'b0, m_req});
    chk("addr",  IMEM_ADDR,            m_pc);
    chk("ir",    IR,                   m_ir);
    chk("ir_pc", IR_PC,                m_irpc);
    chk("valid", {31'b0, IR_VALID},    {31'b0, m_full});
    chk("fault", {31'b0, FETCH_FAULT}, {31'b0, m_fault});
  end

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic fetch(input logic [31:0] data);
    IMEM_GNT = 1; cyc();
    IMEM_GNT = 0; IMEM_RVALID = 1; IMEM_RDATA = data; cyc();
    IMEM_RVALID = 0;
  endtask

  initial begin
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_req", {31'b0, IMEM_REQ}, 32'h0);
    chk("rst_addr", IMEM_ADDR, 32'h0);
    chk("rst_ir", IR, 32'h0000_0013);
    chk("rst_valid", {31'b0, IR_VALID}, 32'h0);
    RST_N = 1;
    cyc();
    chk("first_req", {31'b0, IMEM_REQ}, 32'h1);
    chk("first_addr", IMEM_ADDR, 32'h0);
    fetch(32'h0050_0093);
    chk("f1_ir", IR, 32'h0050_0093);
    chk("f1_pc", IR_PC, 32'h0);
    chk("f1_valid", {31'b0, IR_VALID}, 32'h1);
    chk("f1_next", IMEM_ADDR, 32'h4);

    repeat (5) cyc();
    chk("hold_ir", IR, 32'h0050_0093);
    chk("hold_req", {31'b0, IMEM_REQ}, 32'h0);
    IR_READY = 1; cyc(); IR_READY = 0;
    chk("rel_req", {31'b0, IMEM_REQ}, 32'h1);
    chk("rel_addr", IMEM_ADDR, 32'h4);

    // Stray response with no request outstanding is ignored.
    IMEM_RVALID = 1; IMEM_RDATA = 32'hBAD0_BAD0; cyc();
    IMEM_RVALID = 0;

    IMEM_GNT = 1; cyc(); IMEM_GNT = 0;
    REDIRECT = 1; REDIRECT_PC = 32'h100; cyc(); REDIRECT = 0;
    IMEM_RVALID = 1; IMEM_RDATA = 32'hDEAD_BEEF; cyc();
    IMEM_RVALID = 0;
    chk("rd_valid", {31'b0, IR_VALID}, 32'h0);
    chk("rd_addr", IMEM_ADDR, 32'h100);
    chk("rd_ir", IR, 32'h0050_0093);

    IMEM_GNT = 1; REDIRECT = 1; REDIRECT_PC = 32'h200; cyc();
    IMEM_GNT = 0; REDIRECT = 0;
    chk("drain_req", {31'b0, IMEM_REQ}, 32'h0);
    cyc();
    IMEM_RVALID = 1; IMEM_RDATA = 32'h1111_1111; cyc();
    IMEM_RVALID = 0;
    chk("drain_addr", IMEM_ADDR, 32'h200);
    chk("drain_again", {31'b0, IMEM_REQ}, 32'h1);
    fetch(32'h00A0_0113);
    chk("f2_pc", IR_PC, 32'h200);

    REDIRECT = 1; REDIRECT_PC = 32'hFFFF_FFFC; IR_READY = 1; cyc();
    REDIRECT = 0; IR_READY = 0;
    chk("hr_valid", {31'b0, IR_VALID}, 32'h0);
    chk("hr_addr", IMEM_ADDR, 32'hFFFF_FFFC);
    fetch(32'h1234_5678);
    chk("wrap_pc", IR_PC, 32'hFFFF_FFFC);
    chk("wrap_addr", IMEM_ADDR, 32'h0);
    IR_READY = 1; cyc(); IR_READY = 0;

    IMEM_GNT = 1; cyc(); IMEM_GNT = 0;
    IMEM_RVALID = 1; IMEM_RDATA = 32'hCAFE_F00D;
    REDIRECT = 1; REDIRECT_PC = 32'h300; cyc();
    IMEM_RVALID = 0; REDIRECT = 0;
    chk("rv_addr", IMEM_ADDR, 32'h300);
    chk("rv_ir", IR, 32'h1234_5678);

    REDIRECT = 1; REDIRECT_PC = 32'h102; cyc(); REDIRECT = 0;
`ifdef FETCH_MISALIGN_TRAP_EN
    chk("mis_fault", {31'b0, FETCH_FAULT}, 32'h1);
`else
    chk("mis_addr", IMEM_ADDR, 32'h100);
`endif
    repeat (10) cyc();
    REDIRECT = 1; REDIRECT_PC = 32'h104; cyc(); REDIRECT = 0;
    chk("al_addr", IMEM_ADDR, 32'h104);
    chk("al_fault", {31'b0, FETCH_FAULT}, 32'h0);
    fetch(32'h0000_0073);
    chk("al_pc", IR_PC, 32'h104);
    IR_READY = 1; cyc(); IR_READY = 0;

    IMEM_GNT = 1; cyc(); IMEM_GNT = 0;
    RST_N = 0; #1;
    chk("mid_ir", IR, 32'h0000_0013);
    chk("mid_addr", IMEM_ADDR, 32'h0);
    @(posedge CLK); #1;
    RST_N = 1;
    IMEM_RVALID = 1; IMEM_RDATA = 32'hFFFF_FFFF; cyc();
    IMEM_RVALID = 0;
    chk("post_ir", IR, 32'h0000_0013);
    chk("post_valid", {31'b0, IR_VALID}, 32'h0);
    repeat (3) cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
